// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- bubble presented to IF/ID when nothing is fetched
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Instruction paired with the PC it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally on rdata.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state: flush wins; a pop frees the slot a same-cycle push uses when full
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited memory requests,
// buffers in-order responses with their PCs and drops responses made stale by a redirect.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] PC_out,
    output logic            instr_valid
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic            issue;
    logic            keep_rsp;
    logic            credit_ok;

    logic [XLEN-1:0] pcq_head;
    logic            pcq_empty;
    logic            pcq_full_unused;
    logic [CW-1:0]   pcq_count_unused;

    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [EW-1:0]   ififo_rdata;
    logic            ififo_empty;
    logic            ififo_full_unused;
    logic [CW-1:0]   ififo_count;
    logic            ififo_pop;

    logic [1:0]      bt_lsb_unused;
    assign bt_lsb_unused = branch_target[1:0];

    // Request only when every possible response already has a FIFO slot reserved
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, ififo_count}) < (CW+1)'(DEPTH);
    assign imem_req  = reset && !flush && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;
    assign keep_rsp  = imem_rvalid && !flush && (discard_q == '0);

    // PC of each live outstanding request, in issue order
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (reset),
        .push  (issue),
        .pop   (keep_rsp),
        .flush (flush),
        .wdata (fetch_pc_q),
        .rdata (pcq_head),
        .full  (pcq_full_unused),
        .empty (pcq_empty),
        .count (pcq_count_unused)
    );

    assign push_entry = '{pc: pcq_head, instr: imem_rdata};

    // Returned instructions waiting for IF/ID
    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (keep_rsp),
        .pop   (ififo_pop),
        .flush (flush),
        .wdata (push_entry),
        .rdata (ififo_rdata),
        .full  (ififo_full_unused),
        .empty (ififo_empty),
        .count (ififo_count)
    );

    assign head_entry  = fetch_entry_t'(ififo_rdata);
    assign instr_valid = !ififo_empty;
    assign instr_out   = instr_valid ? head_entry.instr : NOP_INSTR;
    assign PC_out      = instr_valid ? head_entry.pc : '0;
    assign ififo_pop   = instr_valid && !stall && !flush;

    // Next fetch PC, in-flight count and pending-discard count
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
        discard_d     = discard_q;
        if (flush) begin
            fetch_pc_d = {branch_target[XLEN-1:2], 2'b00};
            discard_d  = outstanding_q - CW'(imem_rvalid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // A response with nothing in flight means the memory side lost sync with us
    rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (outstanding_q == '0)));

    // A kept response always has the PC of its request queued
    rsp_has_pc: assert property (@(posedge clk) disable iff (!reset)
        !(keep_rsp && pcq_empty));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit with an in-order variable-latency memory model.
module tb_if_fetch_unit;
    import riscv_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic [31:0] branch_target;
    logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr_out, PC_out;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .PC_out        (PC_out),
        .instr_valid   (instr_valid)
    );

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t mem_q[$];   // requests accepted by memory, awaiting response
    exp_t  exp_q[$];   // instructions IF/ID should see, in order

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    int          flush_seen = 0;
    logic [31:0] model_pc = RESET_PC;

    int          lat = 1;
    int unsigned jit = 0;
    int unsigned gnt_pct = 100, rv_pct = 100, stall_pct = 0, flush_pct = 0;
    bit          force_stall = 0, req_flush = 0, flush_on_rv = 0;
    logic [31:0] flush_tgt = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"},    32'(imem_req), 32'h0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_instr_out"},   instr_out, NOP_INSTR);
        check({tag, "_pc_out"},      PC_out, 32'h0);
        check({tag, "_imem_addr"},   imem_addr, RESET_PC);
    endtask

    // One clock of stimulus: memory response, control inputs, request check, model update
    task automatic step();
        logic  rv;
        logic  issue;
        logic  exp_req;
        mreq_t h;
        int    d;
        @(negedge clk);
        cyc++;
        rv = 1'b0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc && $urandom_range(99) < rv_pct) rv = 1'b1;
        end
        imem_rvalid = rv;
        imem_rdata  = 32'hdead_beef;
        if (rv) imem_rdata = mem_data(mem_q[0].addr);
        stall = force_stall || ($urandom_range(99) < stall_pct);
        flush = req_flush || (flush_on_rv && rv) || ($urandom_range(99) < flush_pct);
        branch_target = (req_flush || flush_on_rv) ? flush_tgt : $urandom;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        #1;
        exp_req = !flush && ((mem_q.size() + exp_q.size()) < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) check("imem_addr", imem_addr, model_pc);
        issue = imem_req && imem_gnt;
        #2;
        if (rv) begin
            h = mem_q.pop_front();
            if (!flush && h.epoch == epoch)
                exp_q.push_back('{pc: h.addr, instr: mem_data(h.addr)});
        end
        if (issue) begin
            d = cyc + lat + int'($urandom_range(jit));
            if (mem_q.size() > 0 && d < mem_q[$].due) d = mem_q[$].due;
            mem_q.push_back('{addr: model_pc, due: d, epoch: epoch});
            model_pc = model_pc + 32'd4;
        end
        if (flush) begin
            model_pc = {branch_target[31:2], 2'b00};
            epoch++;
            flush_seen++;
        end
        req_flush = 1'b0;
    endtask

    task automatic do_reset_mid();
        @(posedge clk);
        #2;
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        mem_q.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        epoch++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: compare the presented head with the scoreboard and retire on consume
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (exp_q.size() > 0) begin
                    check("instr_valid", 32'(instr_valid), 32'h1);
                    check("pc_out", PC_out, exp_q[0].pc);
                    check("instr_out", instr_out, exp_q[0].instr);
                    if (!stall && !flush) void'(exp_q.pop_front());
                end else begin
                    check("bubble_valid", 32'(instr_valid), 32'h0);
                    check("bubble_instr", instr_out, NOP_INSTR);
                    check("bubble_pc", PC_out, 32'h0);
                end
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        int fs;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Single-cycle memory, always granted
        lat = 1; jit = 0;
        repeat (40) step();

        // Three-cycle memory with grant back-pressure
        lat = 3; gnt_pct = 70;
        repeat (60) step();
        gnt_pct = 100;
        repeat (20) step();

        // Long stall: credits exhaust, head holds
        force_stall = 1'b1;
        repeat (10) step();
        force_stall = 1'b0;
        repeat (20) step();

        // Redirect with two requests in flight
        rv_pct = 0;
        for (int i = 0; i < 50; i++) begin
            if (mem_q.size() >= DEPTH) break;
            step();
        end
        check("flush_setup_outstanding", 32'(mem_q.size()), 32'(DEPTH));
        rv_pct = 100; flush_tgt = 32'h100; req_flush = 1'b1;
        step();
        step();
        check("redirect_addr_0x100", imem_addr, 32'h100);
        for (int i = 0; i < 40; i++) begin
            if (instr_valid) break;
            step();
        end
        check("redirect_first_valid", 32'(instr_valid), 32'h1);
        check("redirect_first_pc", PC_out, 32'h100);
        check("redirect_first_instr", instr_out, mem_data(32'h100));

        // Redirect landing on a response, unaligned target
        fs = flush_seen;
        flush_tgt = 32'h203; flush_on_rv = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (flush_seen > fs) break;
            step();
        end
        flush_on_rv = 1'b0;
        check("flush_on_rvalid_seen", 32'(flush_seen > fs), 32'h1);
        step();
        check("redirect_addr_0x200", imem_addr, 32'h200);
        repeat (20) step();

        // Random mix of latency, grants, stalls and redirects
        lat = 1; jit = 3; gnt_pct = 80; rv_pct = 80; stall_pct = 20; flush_pct = 5;
        repeat (300) step();
        flush_pct = 0; stall_pct = 0; rv_pct = 100; gnt_pct = 100;

        // Reset while the FIFO is full
        force_stall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == DEPTH) break;
            step();
        end
        check("fifo_full_before_reset", 32'(exp_q.size()), 32'(DEPTH));
        do_reset_mid();
        force_stall = 1'b0;
        step();
        check("restart_addr", imem_addr, RESET_PC);

        // Drain: everything issued must come out
        lat = 2; jit = 0;
        repeat (30) step();
        rv_pct = 100; gnt_pct = 0;
        repeat (20) step();
        check("drain_outstanding", 32'(mem_q.size()), 32'h0);
        check("drain_valid", 32'(instr_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
